fpu_long_issue: RTL

- Dispatch stage directly upstream of the long-latency FPU unit (div/sqrt/fused class).
- Accepts requests from the pipeline with a valid/ready handshake and queues them in a small FIFO.
- Issues one op at a time to the long unit using a single-cycle `en` pulse, then captures `res` when the unit raises `valid`.
- Presents the result, tagged with its destination register, on a valid/ready writeback port.

---
 rtl/fpu_long_issue_if.sv | 59 +++++
 rtl/fpu_long_issue.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fpu_long_issue_if.sv
// Signal bundle between the pipeline, fpu_long_issue and the long FPU unit.
// timeout_err exists only when FPU_LONG_TIMEOUT_EN is defined.
interface fpu_long_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic [31:0] req_z;
    logic [4:0]  req_funct5;
    logic [2:0]  req_rm;
    logic [4:0]  req_rd;

    logic        fpu_en;
    logic [31:0] fpu_x;
    logic [31:0] fpu_y;
    logic [31:0] fpu_z;
    logic [4:0]  fpu_funct5;
    logic [2:0]  fpu_rm;
    logic [31:0] fpu_res;
    logic        fpu_valid;

    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        busy;

`ifdef FPU_LONG_TIMEOUT_EN
    logic        timeout_err;

    modport slave (
        input  req_valid, req_x, req_y, req_z, req_funct5, req_rm, req_rd,
        input  fpu_res, fpu_valid, wb_ready,
        output req_ready, fpu_en, fpu_x, fpu_y, fpu_z, fpu_funct5, fpu_rm,
        output wb_valid, wb_data, wb_rd, busy, timeout_err
    );

    modport master (
        output req_valid, req_x, req_y, req_z, req_funct5, req_rm, req_rd,
        output fpu_res, fpu_valid, wb_ready,
        input  req_ready, fpu_en, fpu_x, fpu_y, fpu_z, fpu_funct5, fpu_rm,
        input  wb_valid, wb_data, wb_rd, busy, timeout_err
    );
`else
    modport slave (
        input  req_valid, req_x, req_y, req_z, req_funct5, req_rm, req_rd,
        input  fpu_res, fpu_valid, wb_ready,
        output req_ready, fpu_en, fpu_x, fpu_y, fpu_z, fpu_funct5, fpu_rm,
        output wb_valid, wb_data, wb_rd, busy
    );

    modport master (
        output req_valid, req_x, req_y, req_z, req_funct5, req_rm, req_rd,
        output fpu_res, fpu_valid, wb_ready,
        input  req_ready, fpu_en, fpu_x, fpu_y, fpu_z, fpu_funct5, fpu_rm,
        input  wb_valid, wb_data, wb_rd, busy
    );
`endif
endinterface

// File: rtl/fpu_long_issue.sv
// Request FIFO plus one-op-at-a-time dispatcher for the long-latency FPU unit.
// Define FPU_LONG_TIMEOUT_EN to add the WAIT watchdog and sticky timeout_err flag.
module fpu_long_issue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rstn,
    fpu_long_issue_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_e;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [4:0]  funct5;
        logic [2:0]  rm;
        logic [4:0]  rd;
    } op_t;

    op_t         fifoMem_q [DEPTH];
    op_t         reqOp;
    op_t         op_q;
    logic [AW:0] wrPtr_q, wrPtr_d;
    logic [AW:0] rdPtr_q, rdPtr_d;
    logic        reqReady_q;
    logic        fifoEmpty, fullNext, push, pop;
    state_e      state_q, state_d;
    logic [31:0] wbData_q;
    logic        resultTaken;

`ifdef FPU_LONG_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] CanonicalNan = 32'h7FC0_0000;

    logic [CW-1:0] waitCnt_q;
    logic          timeoutErr_q;
    logic          timedOut;
`endif

    assign reqOp     = {bus.req_x, bus.req_y, bus.req_z, bus.req_funct5, bus.req_rm, bus.req_rd};
    assign push      = bus.req_valid && reqReady_q;
    assign fifoEmpty = (wrPtr_q == rdPtr_q);
    assign pop       = (state_q == IDLE) && !fifoEmpty;
    assign wrPtr_d   = wrPtr_q + (AW+1)'(push);
    assign rdPtr_d   = rdPtr_q + (AW+1)'(pop);
    assign fullNext  = (wrPtr_d[AW] != rdPtr_d[AW]) && (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]);

    // Ready is registered from next-cycle fullness, so a same-cycle pop never frees a slot early.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            reqReady_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            reqReady_q <= !fullNext;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q[AW-1:0]] <= reqOp;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        resultTaken = 1'b0;
`ifdef FPU_LONG_TIMEOUT_EN
        timedOut    = 1'b0;
`endif
        case (state_q)
            IDLE:  if (!fifoEmpty) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (bus.fpu_valid) begin
                    resultTaken = 1'b1;
                    state_d     = WB;
                end
`ifdef FPU_LONG_TIMEOUT_EN
                else if (waitCnt_q == CW'(TIMEOUT - 1)) begin
                    timedOut = 1'b1;
                    state_d  = WB;
                end
`endif
            end
            WB:      if (bus.wb_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.fpu_en   = (state_q == ISSUE);
        bus.wb_valid = (state_q == WB);
    end

    // Operand/tag registers load only on pop, so they stay put until the next IDLE->ISSUE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q     <= '0;
            wbData_q <= '0;
        end else begin
            if (pop) op_q <= fifoMem_q[rdPtr_q[AW-1:0]];
            if (resultTaken) wbData_q <= bus.fpu_res;
`ifdef FPU_LONG_TIMEOUT_EN
            else if (timedOut) wbData_q <= CanonicalNan;
`endif
        end
    end

`ifdef FPU_LONG_TIMEOUT_EN
    // Every WAIT entry comes from ISSUE, which is where the watchdog restarts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            waitCnt_q    <= '0;
            timeoutErr_q <= 1'b0;
        end else begin
            if (state_q == ISSUE)     waitCnt_q <= '0;
            else if (state_q == WAIT) waitCnt_q <= waitCnt_q + 1'b1;
            if (timedOut) timeoutErr_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeoutErr_q;
`endif

    assign bus.req_ready  = reqReady_q;
    assign bus.fpu_x      = op_q.x;
    assign bus.fpu_y      = op_q.y;
    assign bus.fpu_z      = op_q.z;
    assign bus.fpu_funct5 = op_q.funct5;
    assign bus.fpu_rm     = op_q.rm;
    assign bus.wb_data    = wbData_q;
    assign bus.wb_rd      = op_q.rd;
    assign bus.busy       = (state_q != IDLE) || !fifoEmpty;
endmodule
